// File: rtl/fdiv_arb_if.sv
// Bundle of every handshake and divider-side signal of the fdiv arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding logic: both requesters, the response consumer and fdiv.
interface fdiv_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_x;
    logic [31:0] req0_y;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_x;
    logic [31:0] req1_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_rslt;
    logic [4:0]  rsp_flag;
    logic        div_req;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic [31:0] div_rslt;
    logic [4:0]  div_flag;

    modport slave (
        input  req0_valid, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_x, req1_y,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_rslt, rsp_flag,
        input  rsp_ready,
        output div_req, div_x, div_y,
        input  div_rslt, div_flag
    );

    modport master (
        output req0_valid, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_x, req1_y,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_rslt, rsp_flag,
        output rsp_ready,
        input  div_req, div_x, div_y,
        output div_rslt, div_flag
    );
endinterface

// File: rtl/fdiv_arb.sv
// Two-port round-robin arbiter and sequencer for one shared iterative fdiv.
// It accepts one op at a time and holds the operands for the whole iteration.
// It pulses div_req once and counts the fixed divider latency. The quotient
// and flags are then parked in a one-entry response buffer. While that buffer
// is full and not draining, the op waits and fdiv keeps presenting its result.
module fdiv_arb #(
    parameter int LAT = 16
) (
    input logic       clk,
    input logic       reset,
    fdiv_arb_if.slave bus_io
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, WAIT} state_t;

    localparam logic [4:0] CAP_CNT = 5'(LAT - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        op_id_q, op_id_d;
    logic [4:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] div_x_q, div_x_d;
    logic [31:0] div_y_q, div_y_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_rslt_q, rsp_rslt_d;
    logic [4:0]  rsp_flag_q, rsp_flag_d;
    logic        grant0, grant1;
    logic        capture;

    // Grant: a lone valid wins outright, and a tie goes to the port named by rr.
    always_comb begin
        grant0 = bus_io.req0_valid & (~bus_io.req1_valid | (rr_q == 1'b0));
        grant1 = bus_io.req1_valid & (~bus_io.req0_valid | (rr_q == 1'b1));
    end

    // Next-state logic for the sequencer, the operand latch and the response buffer.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        op_id_d     = op_id_q;
        lat_cnt_d   = lat_cnt_q;
        div_x_d     = div_x_q;
        div_y_d     = div_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rslt_d  = rsp_rslt_q;
        rsp_flag_d  = rsp_flag_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    op_id_d = grant1;
                    div_x_d = grant1 ? bus_io.req1_x : bus_io.req0_x;
                    div_y_d = grant1 ? bus_io.req1_y : bus_io.req0_y;
                    rr_d    = grant0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = 5'd0;
                state_d   = RUN;
            end
            RUN: begin
                if (lat_cnt_q != 5'h1F) begin
                    lat_cnt_d = lat_cnt_q + 5'd1;
                end
                if (lat_cnt_q == CAP_CNT) begin
                    if (!rsp_valid_q || bus_io.rsp_ready) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_io.rsp_ready) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture refills the buffer even when the old entry drains in the same cycle.
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_id_q;
            rsp_rslt_d  = bus_io.div_rslt;
            rsp_flag_d  = bus_io.div_flag;
        end else if (rsp_valid_q && bus_io.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset. An in-flight op is dropped silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            op_id_q     <= 1'b0;
            lat_cnt_q   <= 5'd0;
            div_x_q     <= 32'd0;
            div_y_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rslt_q  <= 32'd0;
            rsp_flag_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_id_q     <= op_id_d;
            lat_cnt_q   <= lat_cnt_d;
            div_x_q     <= div_x_d;
            div_y_q     <= div_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rslt_q  <= rsp_rslt_d;
            rsp_flag_q  <= rsp_flag_d;
        end
    end

    assign bus_io.req0_ready = (state_q == IDLE) & grant0;
    assign bus_io.req1_ready = (state_q == IDLE) & grant1;
    assign bus_io.div_req    = (state_q == ISSUE);
    assign bus_io.div_x      = div_x_q;
    assign bus_io.div_y      = div_y_q;
    assign bus_io.rsp_valid  = rsp_valid_q;
    assign bus_io.rsp_id     = rsp_id_q;
    assign bus_io.rsp_rslt   = rsp_rslt_q;
    assign bus_io.rsp_flag   = rsp_flag_q;

endmodule

// File: doc/fdiv_arb.md
# fdiv_arb

Two-port round-robin arbiter and sequencer for the shared single-precision iterative divider `fdiv`. It accepts divide requests from two independent requesters over valid/ready handshakes and holds the operands stable for the whole iteration. It issues the one-cycle `req` pulse and times the fixed divider latency, then returns the 32-bit result, 5-bit flags and requester id through a one-entry response buffer with backpressure. It sits between the pipeline issue stages and one `fdiv` instance.

## Interface
- `LAT`, default 16: cycles from the `div_req` cycle to the first cycle `div_rslt`/`div_flag` are valid. This matches the `fdiv` count sequence 1..15 plus the final correction.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset. It is also wired to the `fdiv` `reset`.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_x` in 32: requester 0 dividend, IEEE-754 single.
- `req0_y` in 32: requester 0 divisor, IEEE-754 single.
- `req1_valid` in 1: as `req0_valid`, for requester 1.
- `req1_ready` out 1: as `req0_ready`, for requester 1.
- `req1_x` in 32: as `req0_x`, for requester 1.
- `req1_y` in 32: as `req0_y`, for requester 1.
- `rsp_valid` out 1: response buffer full.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_rslt` out 32: quotient.
- `rsp_flag` out 5: {NV, DZ, OF, UF, NX}.
- `div_req` out 1: one-cycle start pulse to `fdiv.req`.
- `div_x` out 32: registered operand to `fdiv.x`, stable from the ISSUE cycle through capture.
- `div_y` out 32: registered operand to `fdiv.y`, stable from the ISSUE cycle through capture.
- `div_rslt` in 32: `fdiv.rslt`.
- `div_flag` in 5: `fdiv.flag`.

## Operation
- States: IDLE, ISSUE, RUN, WAIT.
- IDLE: the grant is combinational from the valids. If both are valid, the port equal to pointer `rr` wins. `reqN_ready` = (state==IDLE) & grantN.
  - On handshake, latch x/y into `div_x`/`div_y` and the id into `op_id`.
  - Set `rr` to the non-granted port. Go to ISSUE.
  - `rr` is unchanged when no grant occurs.
- ISSUE: `div_req`=1 for exactly this cycle. Clear `lat_cnt` to 0. Go to RUN.
- RUN: `lat_cnt` increments each cycle. `lat_cnt` is 5 bits and saturates; wrap-around is never reached.
  - Capture cycle is the cycle where `lat_cnt`==LAT-1, i.e. the LAT-th cycle after ISSUE.
  - In the capture cycle, if `rsp_valid`==0 or `rsp_ready`==1: load `rsp_rslt`/`rsp_flag` from `div_*`, load `rsp_id` from `op_id`, set `rsp_valid`. Go to IDLE.
  - Otherwise go to WAIT.
- WAIT: `div_x`/`div_y` are held, so `fdiv` output stays valid because `fdiv` holds its state when idle without req. Capture on the first cycle with `rsp_ready`=1, then go to IDLE.
- Response buffer: `rsp_valid` clears on `rsp_valid & rsp_ready` unless a capture occurs in the same cycle. On simultaneous drain and capture, `rsp_valid` stays 1 with the new data.
- `div_x`/`div_y` change only on an IDLE handshake. `div_req` is never asserted outside ISSUE.
- Results and flags pass through unmodified. The arbiter does no exception handling.

## Timing
- Reset values: state IDLE, `rr`=0, `rsp_valid`=0, `div_req`=0, `req0_ready`=`req1_ready`=0 unless IDLE with valid. `rsp_rslt`=0, `rsp_flag`=0, `rsp_id`=0, `div_x`=0, `div_y`=0, `lat_cnt`=0.
- Handshake in cycle A, then:
  - ISSUE in A+1.
  - Capture edge at the end of A+1+LAT.
  - `rsp_valid`=1 from A+LAT+2, i.e. 18 cycles after the handshake for LAT=16.
- Earliest next handshake: A+LAT+2, so sustained throughput is one op per LAT+2 cycles.
- Reset mid-operation, in any state: return to reset values next cycle. The in-flight op is dropped with no response. `fdiv` resets in the same cycle.
- `reqN_x`/`y` need only be valid in the handshake cycle.
- Valid may drop without a handshake. No ready-to-valid dependency exists on the requester side.

## Test plan
- Single op on port 0: x=0x40C00000, y=0x40000000.
  - Required: `rsp_valid` exactly 18 cycles after the handshake, `rsp_rslt`=0x40400000, `rsp_flag`=0x00, `rsp_id`=0.
- Inexact on port 1: x=0x3F800000, y=0x40400000.
  - Required: `rsp_rslt`=0x3EAAAAAB, `rsp_flag`=0x01, `rsp_id`=1.
- Divide by zero: x=0x3F800000, y=0x00000000.
  - Required: `rsp_rslt`=0x7F800000, `rsp_flag`=0x08.
  - 0/0 gives 0xFFC00000, flag 0x10.
- Contention: both ports valid continuously, 4 ops each.
  - Required: grants alternate 0,1,0,1,…. `div_req` pulses are spaced 18 cycles apart. Each op is accepted exactly once.
- Backpressure: `rsp_ready`=0 for 60 cycles with two ops queued.
  - Required: first response held unchanged, second op enters WAIT with `div_x`/`div_y` stable.
  - After `rsp_ready`=1, both responses are delivered in order with correct values and there is no third `div_req` until the second capture.
- Reset at RUN `lat_cnt`=7.
  - Required: next cycle all outputs are at reset values with no response emitted. A following 0x40C00000/0x40000000 op returns 0x40400000.
